ir_pio_edge_sequencer: RTL and testbench
========================================

# ir_pio_edge_sequencer

Avalon-MM master that owns the IR input PIO's slave port and turns its edge-capture interrupts into timed pulse records. On enable it programs the PIO's interrupt mask and clears its capture register. It then services every edge interrupt: read the pin level, clear the capture, measure the elapsed time since the previous edge. Each result goes into a small FIFO as a {level, width} event for the downstream protocol decoder, so the NIOS no longer services the IR interrupt directly.

## Interface
- TICK_DIV, 50, clk cycles per width tick (50 gives 1 µs at 50 MHz); legal range ≥2.
- WIDTH_BITS, 16, width of the tick counter and of evt_width.
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run the sequencer, 0 = park the PIO.
- pio_address  out  2  PIO register select (0 data, 2 irq mask, 3 edge capture).
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO active-low write strobe.
- pio_writedata  out  32  PIO write data.
- pio_readdata  in  32  PIO read data; registered in the PIO, valid one cycle after pio_address is presented.
- pio_irq  in  1  PIO interrupt (edge_capture & mask).
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
- evt_level  out  1  pin level after the edge (bit 0 of PIO data).
- evt_width  out  WIDTH_BITS  ticks the pin spent at ~evt_level before this edge.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- overflow_clr  in  1  single-cycle clear of overflow.

## Operation
- Tick prescaler: counts 0..TICK_DIV-1 while state ≠ IDLE. It wraps to 0 and emits a tick.
- Width counter: increments on each tick and saturates at all-ones (no wrap).
- States and transitions:
  - IDLE: all bus outputs inactive. Moves to MASK when enable=1.
  - MASK: write addr 2 with data 1. Moves to INIT_CLR.
  - INIT_CLR: write addr 3 with data 1. Clears the prescaler and width counter. Moves to WAIT.
  - WAIT: watches pio_irq and enable.
    - enable=0 → UNMASK.
    - Otherwise pio_irq=1 → ADDR. In the same cycle the width counter value is latched into width_hold, and the width counter and prescaler restart from 0.
  - ADDR: presents pio_address=0, chipselect=1, write_n=1. Moves to CAPT.
  - CAPT: latches pio_readdata[0] into level_hold. Moves to CLR.
  - CLR: write addr 3 with data 1. Moves to PUSH.
  - PUSH: if the FIFO is not full, writes {level_hold, width_hold}; if full, sets overflow and discards the event. Moves to WAIT.
  - UNMASK: write addr 2 with data 0. Moves to IDLE.
- enable is sampled only in IDLE and WAIT. A service sequence already in progress always completes.
- Bus writes last exactly one cycle: chipselect=1, write_n=0. At all other times chipselect=0, write_n=1, address=0, writedata=0.
- FIFO:
  - Show-ahead: evt_level and evt_width reflect the head entry whenever evt_valid=1.
  - A push and a pop in the same cycle are both honoured.
  - "Full" is evaluated before any same-cycle pop, so a push against a full FIFO drops even when a pop occurs in that cycle.
  - FIFO contents persist across enable toggles. Only reset empties the FIFO.
- overflow: if overflow_clr and a new drop happen in the same cycle, overflow stays 1 (set wins).

## Timing
- Reset values: pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, evt_valid 0, evt_level 0, evt_width 0, overflow 0. State is IDLE, FIFO empty, all counters 0.
- Bring-up: the MASK write occurs the 1st cycle after enable is sampled high; INIT_CLR is the 2nd.
- Service: pio_irq seen in WAIT at cycle N.
  - ADDR at N+1, CAPT at N+2, CLR write at N+3, PUSH at N+4.
  - evt_valid=1 at N+5 if the FIFO was empty.
  - Back in WAIT at N+5; the earliest next irq acceptance is N+5.
- Edge limitation: an edge whose capture coincides with the CLR write is lost, because the PIO's clear has priority. The minimum resolvable pulse is therefore 5 clk.
- Width resolution: accuracy is ±1 tick. The measured interval includes the PIO's 2-flop synchroniser delay, which is the same for every edge and cancels between successive events.
- Asynchronous reset mid-sequence returns every output to its reset value immediately. No bus cleanup is performed; the PIO is reset by the same reset_n.

## Test plan
- Bring-up: reset, then enable=1 → exactly two writes: addr 2 data 1, then addr 3 data 1. evt_valid stays 0.
- Single edge: TICK_DIV=4, hold the pin low 400 clk, then raise it (PIO model) → one event with level=1, width=100 (±1). Bus shows read addr 0 then write addr 3 data 1. evt_valid rises 5 cycles after irq.
- Saturation: WIDTH_BITS=4, TICK_DIV=2, gap 100 clk between edges → width=15.
- Overflow: FIFO_DEPTH=2, evt_ready=0, three edges spaced 50 clk → two events queued and overflow=1. Pulse overflow_clr → overflow=0. Popping both entries yields widths in arrival order.
- Disable mid-service: drop enable during ADDR → CAPT, CLR and PUSH still complete, then one addr 2 data 0 write, then IDLE. The event remains poppable.
- Simultaneous push/pop on a full FIFO: event dropped and overflow set. Push/pop on a non-full FIFO: occupancy unchanged, data ordering correct.

Source files
------------

// File: rtl/ir_pio_edge_sequencer_if.sv
// ir_pio_edge_sequencer_if
//   Avalon-MM connection between the edge sequencer (master) and the IR
//   input PIO slave port, including the PIO's interrupt line.
//   pio_address    : register select (0 data, 2 irq mask, 3 edge capture)
//   pio_chipselect : slave select
//   pio_write_n    : active-low write strobe
//   pio_writedata  : write data
//   pio_readdata   : registered read data, valid one cycle after the address
//   pio_irq        : edge_capture & mask
`timescale 1ns/1ps
interface ir_pio_edge_sequencer_if;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata, pio_irq
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata, pio_irq
    );
endinterface

// File: rtl/ir_pio_edge_sequencer.sv
// ir_pio_edge_sequencer
//   Owns the IR input PIO: arms its edge interrupt, services every edge
//   (read level, clear capture, measure time since the previous edge) and
//   queues {level, width} events for the downstream protocol decoder.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : 1 = run, 0 = mask the PIO interrupt and park
//   pio           : Avalon-MM master side of the PIO connection
//   evt_valid     : event FIFO non-empty
//   evt_ready     : consumer pop (pop when evt_valid && evt_ready)
//   evt_level     : pin level after the edge (head entry)
//   evt_width     : ticks the pin spent at ~evt_level (head entry)
//   overflow      : sticky, an event was dropped on a full FIFO
//   overflow_clr  : single-cycle clear of overflow (a same-cycle drop wins)
`timescale 1ns/1ps
module ir_pio_edge_sequencer #(
    parameter int TICK_DIV   = 50,
    parameter int WIDTH_BITS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    ir_pio_edge_sequencer_if.master   pio,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic                      evt_level,
    output logic [WIDTH_BITS-1:0]     evt_width,
    output logic                      overflow,
    input  logic                      overflow_clr
);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, MASK, INIT_CLR, WAIT, ADDR, CAPT, CLR, PUSH, UNMASK
    } state_t;

    state_t                state;
    logic [PRESC_W-1:0]    presc;
    logic [WIDTH_BITS-1:0] width_cnt;
    logic [WIDTH_BITS-1:0] width_hold;
    logic                  level_hold;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [WIDTH_BITS:0]   fifo_mem [FIFO_DEPTH];
    logic [WIDTH_BITS:0]   fifo_head;
    logic                  fifo_full;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  edge_accept;
    logic                  unused_readdata;

    // Width counter sticks at all-ones so a long idle line reads as "very long"
    // rather than wrapping into a short, plausible-looking pulse.
    function automatic logic [WIDTH_BITS-1:0] sat_inc(input logic [WIDTH_BITS-1:0] v);
        return (&v) ? v : v + WIDTH_BITS'(1);
    endfunction

    assign edge_accept     = (state == WAIT) && enable && pio.pio_irq;
    assign unused_readdata = ^pio.pio_readdata[31:1];

    // Full is judged on the pointers before any same-cycle pop.
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push      = (state == PUSH) && !fifo_full;
    assign drop      = (state == PUSH) && fifo_full;
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid && evt_ready;
    assign fifo_head = fifo_mem[rd_ptr[AW-1:0]];
    assign evt_level = evt_valid ? fifo_head[WIDTH_BITS] : 1'b0;
    assign evt_width = evt_valid ? fifo_head[WIDTH_BITS-1:0] : '0;

    // Sequencer; bus outputs are registered and describe the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            pio.pio_chipselect <= 1'b0;
            pio.pio_write_n    <= 1'b1;
            pio.pio_address    <= 2'd0;
            pio.pio_writedata  <= 32'd0;
        end else begin
            pio.pio_chipselect <= 1'b0;
            pio.pio_write_n    <= 1'b1;
            pio.pio_address    <= 2'd0;
            pio.pio_writedata  <= 32'd0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state              <= MASK;
                        pio.pio_chipselect <= 1'b1;
                        pio.pio_write_n    <= 1'b0;
                        pio.pio_address    <= 2'd2;
                        pio.pio_writedata  <= 32'd1;
                    end
                end
                MASK: begin
                    state              <= INIT_CLR;
                    pio.pio_chipselect <= 1'b1;
                    pio.pio_write_n    <= 1'b0;
                    pio.pio_address    <= 2'd3;
                    pio.pio_writedata  <= 32'd1;
                end
                INIT_CLR: state <= WAIT;
                WAIT: begin
                    if (!enable) begin
                        state              <= UNMASK;
                        pio.pio_chipselect <= 1'b1;
                        pio.pio_write_n    <= 1'b0;
                        pio.pio_address    <= 2'd2;
                        pio.pio_writedata  <= 32'd0;
                    end else if (pio.pio_irq) begin
                        state              <= ADDR;
                        pio.pio_chipselect <= 1'b1;
                    end
                end
                ADDR: state <= CAPT;
                CAPT: begin
                    state              <= CLR;
                    pio.pio_chipselect <= 1'b1;
                    pio.pio_write_n    <= 1'b0;
                    pio.pio_address    <= 2'd3;
                    pio.pio_writedata  <= 32'd1;
                end
                CLR:     state <= PUSH;
                PUSH:    state <= WAIT;
                UNMASK:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler and width counter; both restart when an edge is accepted so
    // the next measurement begins at the edge just serviced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            width_cnt <= '0;
        end else if ((state == INIT_CLR) || edge_accept) begin
            presc     <= '0;
            width_cnt <= '0;
        end else if (state != IDLE) begin
            if (presc == PRESC_LAST) begin
                presc     <= '0;
                width_cnt <= sat_inc(width_cnt);
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    // Event fields; PIO read data is valid during CAPT (address went out in ADDR).
    always_ff @(posedge clk) begin
        if (edge_accept)
            width_hold <= width_cnt;
        if (state == CAPT)
            level_hold <= pio.pio_readdata[0];
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {level_hold, width_hold};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ir_pio_edge_sequencer.sv
// Bench for ir_pio_edge_sequencer: a behavioural PIO slave (2-flop
// synchroniser, edge capture with clear priority, irq mask, registered
// read data), a bus logger, and an event scoreboard.
`timescale 1ns/1ps
module tb_ir_pio_edge_sequencer;
    localparam int TD = 4;
    localparam int WB = 8;
    localparam int FD = 2;

    typedef struct { logic lvl; logic [WB-1:0] w; } exp_t;
    typedef struct { int cyc; bit wr; logic [1:0] addr; logic [31:0] data; } bus_t;
    typedef struct { int gap; logic lvl; int exp_w; } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          evt_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          evt_valid;
    logic          evt_level;
    logic [WB-1:0] evt_width;
    logic          overflow;

    ir_pio_edge_sequencer_if pio_bus();

    ir_pio_edge_sequencer #(.TICK_DIV(TD), .WIDTH_BITS(WB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pio(pio_bus),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_level(evt_level),
        .evt_width(evt_width), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave model
    logic        pin = 1'b0;
    logic        s1, s2, prev, capture, mask;
    logic [31:0] rdata;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0; s2 <= 1'b0; prev <= 1'b0;
            capture <= 1'b0; mask <= 1'b0; rdata <= 32'd0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            prev <= s2;
            if (pio_bus.pio_chipselect && !pio_bus.pio_write_n && pio_bus.pio_address == 2'd3)
                capture <= 1'b0;
            else if (s2 != prev)
                capture <= 1'b1;
            if (pio_bus.pio_chipselect && !pio_bus.pio_write_n && pio_bus.pio_address == 2'd2)
                mask <= pio_bus.pio_writedata[0];
            case (pio_bus.pio_address)
                2'd0:    rdata <= {31'd0, s2};
                2'd2:    rdata <= {31'd0, mask};
                2'd3:    rdata <= {31'd0, capture};
                default: rdata <= 32'd0;
            endcase
        end
    end
    assign pio_bus.pio_readdata = rdata;
    assign pio_bus.pio_irq      = capture & mask;

    int   n_chk = 0;
    int   n_fail = 0;
    int   last_ref = 0;
    exp_t sb[$];
    bus_t bus_log[$];
    exp_t mon_e;
    logic bus_idle_bad = 1'b0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Bus logger and event scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pio_bus.pio_chipselect)
                bus_log.push_back('{cyc, !pio_bus.pio_write_n, pio_bus.pio_address, pio_bus.pio_writedata});
            else if (pio_bus.pio_write_n !== 1'b1 || pio_bus.pio_address !== 2'd0 ||
                     pio_bus.pio_writedata !== 32'd0)
                bus_idle_bad <= 1'b1;
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_evt");
                end else begin
                    mon_e = sb.pop_front();
                    check("evt_level", {31'd0, evt_level}, {31'd0, mon_e.lvl});
                    check_tol("evt_width", int'(evt_width), int'(mon_e.w), 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic edge_at(input int gap, input logic lvl, input bit push_exp, input int expw);
        wait_until(last_ref + gap);
        pin = lvl;
        last_ref = cyc;
        if (push_exp) sb.push_back('{lvl: lvl, w: WB'(expw)});
    endtask

    task automatic wait_irq(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (pio_bus.pio_irq) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            fail_now("irq_timeout");
            n = cyc;
        end
    endtask

    task automatic check_bus(input string name, input int idx, input int c, input bit wr,
                             input logic [1:0] a, input logic [31:0] d);
        if (idx >= bus_log.size()) begin
            fail_now({name, "_missing"});
        end else begin
            check({name, "_cyc"},  bus_log[idx].cyc, c);
            check({name, "_wr"},   {31'd0, bus_log[idx].wr}, {31'd0, wr});
            check({name, "_addr"}, {30'd0, bus_log[idx].addr}, {30'd0, a});
            check({name, "_data"}, bus_log[idx].data, d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;
        vecs[0] = '{400, 1'b1, 100};
        vecs[1] = '{60,  1'b0, 15};
        vecs[2] = '{200, 1'b1, 50};
        vecs[3] = '{1500, 1'b0, 255};
        vecs[4] = '{37,  1'b1, 9};
        vecs[5] = '{11,  1'b0, 2};
        vecs[6] = '{120, 1'b1, 30};

        // Reset values
        tick(3);
        check("rst_cs",    {31'd0, pio_bus.pio_chipselect}, 32'd0);
        check("rst_wn",    {31'd0, pio_bus.pio_write_n}, 32'd1);
        check("rst_addr",  {30'd0, pio_bus.pio_address}, 32'd0);
        check("rst_wdata", pio_bus.pio_writedata, 32'd0);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_level", {31'd0, evt_level}, 32'd0);
        check("rst_width", {24'd0, evt_width}, 32'd0);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick(5);
        check("idle_quiet", bus_log.size(), 0);

        // Bring-up: mask write then capture clear
        enable = 1'b1;
        e = cyc;
        last_ref = e;
        tick(4);
        check("bringup_nwr", bus_log.size(), 2);
        check_bus("bringup_mask", 0, e + 1, 1'b1, 2'd2, 32'd1);
        check_bus("bringup_clr",  1, e + 2, 1'b1, 2'd3, 32'd1);
        check("bringup_valid", {31'd0, evt_valid}, 32'd0);

        // Single edge: timing of the service and evt_valid
        bus_log.delete();
        edge_at(400, 1'b1, 1'b1, 100);
        wait_irq(n);
        wait_until(n + 4);
        check("svc_valid_n4", {31'd0, evt_valid}, 32'd0);
        tick(1);
        check("svc_valid_n5", {31'd0, evt_valid}, 32'd1);
        check("svc_nbus", bus_log.size(), 2);
        check_bus("svc_read", 0, n + 1, 1'b0, 2'd0, 32'd0);
        check_bus("svc_clr",  1, n + 3, 1'b1, 2'd3, 32'd1);
        evt_ready = 1'b1;
        tick(3);
        evt_ready = 1'b0;
        check("svc_drained", {31'd0, evt_valid}, 32'd0);

        // Overflow: three edges into a two-entry FIFO
        edge_at(50, 1'b0, 1'b1, 12);
        edge_at(50, 1'b1, 1'b1, 12);
        edge_at(50, 1'b0, 1'b0, 0);
        tick(12);
        check("ovf_set",   {31'd0, overflow}, 32'd1);
        check("ovf_valid", {31'd0, evt_valid}, 32'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        evt_ready = 1'b1;
        tick(4);
        evt_ready = 1'b0;
        check("ovf_drained", {31'd0, evt_valid}, 32'd0);
        check("ovf_sb_empty", sb.size(), 0);

        // Table of edges with a free-running consumer, including saturation
        evt_ready = 1'b1;
        for (int i = 0; i < 7; i++)
            edge_at(vecs[i].gap, vecs[i].lvl, 1'b1, vecs[i].exp_w);
        tick(20);
        evt_ready = 1'b0;
        check("tbl_sb_empty", sb.size(), 0);

        // Disable during ADDR: service completes, then unmask, then idle
        bus_log.delete();
        edge_at(100, 1'b0, 1'b1, 25);
        wait_irq(n);
        tick(1);
        enable = 1'b0;
        wait_until(n + 12);
        check("dis_nbus", bus_log.size(), 3);
        check_bus("dis_read",   0, n + 1, 1'b0, 2'd0, 32'd0);
        check_bus("dis_clr",    1, n + 3, 1'b1, 2'd3, 32'd1);
        check_bus("dis_unmask", 2, n + 6, 1'b1, 2'd2, 32'd0);
        check("dis_valid", {31'd0, evt_valid}, 32'd1);
        evt_ready = 1'b1;
        tick(2);
        evt_ready = 1'b0;
        check("dis_sb_empty", sb.size(), 0);

        // Re-enable; push/pop against a full FIFO drops the event
        enable = 1'b1;
        last_ref = cyc;
        edge_at(80, 1'b1, 1'b1, 20);
        edge_at(80, 1'b0, 1'b1, 20);
        edge_at(80, 1'b1, 1'b0, 0);
        wait_irq(n);
        wait_until(n + 4);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        wait_until(n + 10);
        check("full_pp_ovf",   {31'd0, overflow}, 32'd1);
        check("full_pp_valid", {31'd0, evt_valid}, 32'd1);
        check("full_pp_sb",    sb.size(), 1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;

        // Push/pop on a non-full FIFO keeps occupancy and order
        edge_at(80, 1'b0, 1'b1, 20);
        wait_irq(n);
        wait_until(n + 4);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("pp_valid_one", {31'd0, evt_valid}, 32'd1);
        check("pp_ovf",       {31'd0, overflow}, 32'd0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("pp_valid_zero", {31'd0, evt_valid}, 32'd0);
        check("pp_sb_empty", sb.size(), 0);

        check("bus_idle_values", {31'd0, bus_idle_bad}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
